// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative read-only I-cache, true-LRU, blocking burst refill.
// Define ICACHE_STATS_EN to get saturating hit/miss counters; otherwise both read 0.
module icache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 6,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  invalidate,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OB   = $clog2(LINE_WORDS);
  localparam int WB   = OB > 0 ? OB : 1;
  localparam int AW   = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int SETS = 1 << SET_BITS;
  localparam int TW   = ADDR_WIDTH - 2 - OB - SET_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WAYS-1:0]       valid [SETS];
  logic [TW-1:0]         tags [WAYS][SETS];
  logic [AW-1:0]         age [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data [WAYS][SETS][LINE_WORDS];
  logic [AW-1:0]         victim, vic, hit_way, acc;
  logic [AW-1:0]         lru_new [WAYS];
  logic [WB-1:0]         cnt, wrd;
  logic [SET_BITS-1:0]   idx;
  logic [TW-1:0]         tag;
  logic                  hit, inv_pend, clr, last_word;
  logic [DATA_WIDTH-1:0] last_data, cur_word;
  assign idx          = SET_BITS'(addr_q >> (2 + OB));
  assign tag          = TW'(addr_q >> (2 + OB + SET_BITS));
  assign wrd          = WB'(addr_q >> 2) & WB'(LINE_WORDS - 1);
  assign last_word    = cnt == WB'(LINE_WORDS - 1);
  assign req_ready    = state == IDLE && !invalidate;
  assign mem_req_valid = state == MISS_REQ;
  assign mem_req_addr = addr_q & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  assign rsp_valid    = (state == LOOKUP && hit) || state == RESP;
  assign cur_word     = data[acc][idx][wrd];
  assign rsp_data     = rsp_valid ? cur_word : last_data;
  // A deferred clear lands on RESP exit so the refilled line is dropped too.
  assign clr = (invalidate && (state == IDLE || state == LOOKUP)) || (state == RESP && (inv_pend || invalidate));
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vic = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
      if (age[idx][w] == AW'(WAYS - 1)) vic = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) if (!valid[idx][w]) vic = AW'(w);
    acc = state == LOOKUP ? hit_way : victim;
    for (int w = 0; w < WAYS; w++)
      lru_new[w] = AW'(w) == acc ? '0 : age[idx][w] < age[idx][acc] ? age[idx][w] + 1'b1 : age[idx][w];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      victim <= '0;
      cnt <= '0;
      inv_pend <= 1'b0;
      last_data <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
    end else begin
      if (rsp_valid) last_data <= cur_word;
      case (state)
        IDLE: if (req_ready && req_valid) begin
          addr_q <= req_addr;
          state <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) age[idx] <= lru_new;
          victim <= vic;
          cnt <= '0;
          state <= hit ? IDLE : MISS_REQ;
        end
        MISS_REQ: begin
          if (invalidate) inv_pend <= 1'b1;
          if (mem_req_ready) state <= REFILL;
        end
        REFILL: begin
          if (invalidate) inv_pend <= 1'b1;
          if (mem_rsp_valid) begin
            cnt <= WB'(cnt + 1'b1);
            if (last_word) begin
              valid[idx][victim] <= 1'b1;
              age[idx] <= lru_new;
              state <= RESP;
            end
          end
        end
        default: begin
          inv_pend <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (clr) for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end
  end
  always_ff @(posedge clock) begin
    if (state == REFILL && mem_rsp_valid) begin
      data[victim][idx][cnt] <= mem_rsp_data;
      if (last_word) tags[victim][idx] <= tag;
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hits, misses;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hits <= '0;
      misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hits != '1) hits <= hits + 1'b1;
      if (!hit && misses != '1) misses <= misses + 1'b1;
    end
  end
  assign hit_count  = hits;
  assign miss_count = misses;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed checks of hit/miss, LRU eviction, stalls, invalidate and reset abort.
module tb_icache_assoc;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, rsp_valid, invalidate = 1'b0;
  logic [31:0] req_addr = '0, rsp_data, mem_req_addr, mem_rsp_data = '0, hit_count, miss_count;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  int          checks = 0, errors = 0, mem_reqs = 0, rdy_delay = 0, gap = 0;
  logic [31:0] last_line = '0;
  icache_assoc dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .invalidate(invalidate), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .hit_count(hit_count), .miss_count(miss_count)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] word(input logic [31:0] line, input int i);
    return 32'(i + 1) * 32'h11 + ((line ^ 32'h100) << 8);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Memory model: optional ready stall, then LINE_WORDS words with optional gaps.
  initial forever begin
    @(negedge clock);
    if (mem_req_valid) begin
      logic [31:0] line;
      line = mem_req_addr;
      last_line = line;
      mem_reqs++;
      for (int k = 0; k < rdy_delay; k++) begin
        @(negedge clock);
        check("req_stable", {31'b0, mem_req_valid && mem_req_addr == line}, 32'd1);
      end
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        repeat (gap) @(negedge clock);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = word(line, i);
        @(negedge clock);
        mem_rsp_valid = 1'b0;
      end
    end
  end
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_addr = a;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 200) check("rsp_timeout", 32'(lat), 32'd0);
    d = rsp_data;
  endtask
  task automatic read_chk(input string tag, input logic [31:0] a, input logic miss);
    logic [31:0] d;
    int lat, r0;
    r0 = mem_reqs;
    fetch(a, d, lat);
    check({tag, "_data"}, d, word(a & ~32'hF, int'(a[3:2])));
    check({tag, "_miss"}, 32'(mem_reqs - r0), {31'b0, miss});
    if (!miss) check({tag, "_lat"}, 32'(lat), 32'd1);
  endtask
  initial begin
    logic [31:0] d;
    int lat, n;
    repeat (3) @(negedge clock);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    reset = 1'b0;
    fetch(32'h104, d, lat);
    check("cold_line_addr", last_line, 32'h100);
    check("cold_data", d, 32'h22);
    read_chk("warm", 32'h10C, 1'b0);
    check("warm_data_const", rsp_data, 32'h44);
    read_chk("fill_way1", 32'h10100, 1'b1);
    read_chk("reread_a", 32'h100, 1'b0);
    read_chk("evict", 32'h20100, 1'b1);
    read_chk("a_survives", 32'h100, 1'b0);
    read_chk("b_evicted", 32'h10100, 1'b1);
    rdy_delay = 5;
    gap = 2;
    read_chk("stall", 32'h308, 1'b1);
    @(negedge clock);
    check("single_pulse", {31'b0, rsp_valid}, 32'd0);
    check("hold_data", rsp_data, word(32'h300, 2));
    rdy_delay = 0;
    gap = 1;
    fork
      read_chk("inv_refill", 32'h200, 1'b1);
      begin
        for (int k = 0; k < 100 && !mem_rsp_valid; k++) @(negedge clock);
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
      end
    join
    gap = 0;
    read_chk("inv_remiss", 32'h200, 1'b1);
    @(negedge clock);
    req_valid = 1'b1;
    req_addr = 32'h400;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      @(negedge clock);
      #2;
      if (mem_rsp_valid) n++;
    end
    reset = 1'b1;
    #1;
    check("abort_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    read_chk("abort_remiss", 32'h400, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    read_chk("st_m0", 32'h100, 1'b1);
    read_chk("st_m1", 32'h200, 1'b1);
    read_chk("st_m2", 32'h300, 1'b1);
    read_chk("st_h0", 32'h104, 1'b0);
    read_chk("st_h1", 32'h108, 1'b0);
    read_chk("st_h2", 32'h204, 1'b0);
    read_chk("st_h3", 32'h30C, 1'b0);
    read_chk("st_h4", 32'h100, 1'b0);
    @(negedge clock);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, 32'd5);
    check("miss_count", miss_count, 32'd3);
`else
    check("hit_count", hit_count, 32'd0);
    check("miss_count", miss_count, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative, read-only instruction cache with multi-word lines and true-LRU replacement.
- Sits between the fetch stage and instruction memory.
- Fetch side uses a valid/ready request channel and a one-cycle-latency response.
- On a miss, a blocking refill FSM fetches a whole line from memory as a burst over a handshaked memory port.
- A single-cycle invalidate supports self-modifying-code and program-load flows.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, instruction word width; must be 32.
- SET_BITS, 6, log2 of the number of sets (64).
- WAYS, 2, associativity; power of 2, range 1..8.
- LINE_WORDS, 4, words per line; power of 2, range 1..16.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- req_ready  out  1  cache can accept a request this cycle
- rsp_valid  out  1  rsp_data valid; one-cycle pulse
- rsp_data  out  DATA_WIDTH  fetched instruction
- invalidate  in  1  clear all valid bits
- mem_req_valid  out  1  line refill request
- mem_req_addr  out  ADDR_WIDTH  line-aligned refill address
- mem_req_ready  in  1  memory accepted the request
- mem_rsp_valid  in  1  one refill word present
- mem_rsp_data  in  DATA_WIDTH  refill word; arrives in ascending word order
- hit_count  out  32  statistics, see Optional Feature
- miss_count  out  32  statistics, see Optional Feature

Behaviour:
- Address split, LSB first:
  - byte offset: 2 bits
  - word offset: log2(LINE_WORDS) bits
  - index: SET_BITS bits
  - tag: the remaining bits
- Storage per way per set:
  - valid bit
  - tag
  - LINE_WORDS data words
  - log2(WAYS)-bit LRU age
- Reset (asynchronous): all valid bits 0, ages reset to way index, FSM to IDLE. Output reset values:
  - req_ready=1
  - rsp_valid=0, rsp_data=0
  - mem_req_valid=0, mem_req_addr=0
  - hit_count=0, miss_count=0
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE, req_ready=1: on req_valid, latch the address and go to LOOKUP.
- LOOKUP, req_ready=0, tag compare across all ways:
  - Hit: rsp_valid=1 with the word this cycle (request accepted at edge N gives rsp_valid in cycle N+1), update LRU, return to IDLE. Back-to-back hits sustain one fetch per 2 cycles.
  - Miss: choose the victim, go to MISS_REQ.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way with the maximum age.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = latched address with word/byte offset bits zeroed.
  - Hold valid and address stable until mem_req_ready; then go to REFILL.
- REFILL:
  - Each mem_rsp_valid writes the next word into the victim line; the word counter wraps at LINE_WORDS.
  - Gaps between words are allowed.
  - After the last word: set the victim's valid bit and tag, update LRU, go to RESP.
- RESP: rsp_valid=1 with the requested word from the refilled line, then IDLE. Miss latency = 3 + memory handshake cycles + LINE_WORDS.
- LRU update for an accessed way: its age becomes 0; every way whose age was below its old age increments; the others are unchanged. WAYS=1 makes LRU trivial.
- invalidate:
  - In IDLE or LOOKUP: all valid bits clear at the next edge. A LOOKUP in that same cycle still completes using the pre-clear state.
  - In MISS_REQ/REFILL: the clear is deferred and applied as RESP exits, so the in-flight refill response completes; the refilled line is also invalidated.
  - An invalidate in IDLE has priority over accepting req_valid the same cycle: req_ready=0 that cycle.
- mem_rsp_valid outside REFILL is ignored.
- Reset asserted mid-refill: the FSM aborts to IDLE, the partial line is never marked valid, mem_req_valid drops immediately.
- rsp_data holds its last value when rsp_valid=0.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each LOOKUP hit; miss_count increments on each LOOKUP miss.
  - Both are 32-bit, saturating at 0xFFFFFFFF, and cleared by reset only (not by invalidate).
- Undefined: both ports are driven constant 0 and no counter flops are generated.

Test Plan:
- Defaults: cold read 0x00000104 (mem returns 0x11,0x22,0x33,0x44 for words 0..3) -> mem_req_addr=0x00000100, rsp_data=0x22; then read 0x0000010C -> hit, rsp_data=0x44, one cycle after accept, no mem_req_valid.
- Same set conflict: fill 0x00000100 (way0), 0x00010100 (way1), re-read 0x00000100, then miss on 0x00020100 -> way1 evicted (LRU); re-read 0x00000100 hits, 0x00010100 misses.
- mem_req_ready held low 5 cycles and mem_rsp_valid with 2-cycle gaps -> mem_req_valid/addr stable throughout, correct word returned, rsp_valid exactly one pulse.
- invalidate pulsed during REFILL of 0x00000200 -> response delivered; a following read of 0x00000200 misses again.
- Reset asserted at the second refill word -> mem_req_valid=0 and req_ready=1 immediately; a subsequent read of the same address misses.
- With ICACHE_STATS_EN, 3 misses + 5 hits -> miss_count=3, hit_count=5; without the macro, both read 0.
